// File: rtl/video_pkg.sv
// Shared scanline definitions: mode encodings, colour-depth derivation, pipeline depth.
// Pure declarations; no timing or flow control of its own.
package video_pkg;

  typedef enum logic [1:0] {
    SL_OFF = 2'd0,
    SL_75  = 2'd1,
    SL_50  = 2'd2,
    SL_25  = 2'd3
  } sl_mode_t;

  localparam int SL_LATENCY = 2;

  function automatic int dw_of(input int half_depth);
    return (half_depth != 0) ? 3 : 6;
  endfunction

endpackage

// File: rtl/sl_attenuate.sv
// Per-channel scanline attenuator, purely combinational (0 latency).
// No flow control; the caller registers the result on its pixel strobe.
module sl_attenuate
  import video_pkg::*;
#(
  parameter int DW = 6
) (
  input  logic [DW-1:0] value,
  input  logic [1:0]    mode,
  input  logic          enable,
  output logic [DW-1:0] result
);

  always_comb begin
    result = value;
    if (enable) begin
      case (sl_mode_t'(mode))
        SL_OFF:  result = value;
        SL_75:   result = value - (value >> 2);
        SL_50:   result = value >> 1;
        SL_25:   result = value >> 2;
        default: result = value;
      endcase
    end
  end

endmodule

// File: rtl/video_scanlines.sv
// Scanline dimmer for doubled video: 2 ce_pix strobes of latency, holds between strobes.
// Optional composite sync on csync_out when VIDEO_SCANLINES_CSYNC_EN is defined.
module video_scanlines
  import video_pkg::*;
#(
  parameter  int HALF_DEPTH = 0,
  localparam int DW         = dw_of(HALF_DEPTH)
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          ce_pix,
  input  logic [1:0]    scanlines,
  input  logic          hs_in,
  input  logic          vs_in,
  input  logic [DW-1:0] r_in,
  input  logic [DW-1:0] g_in,
  input  logic [DW-1:0] b_in,
  output logic          hs_out,
  output logic          vs_out,
  output logic [DW-1:0] r_out,
  output logic [DW-1:0] g_out,
  output logic [DW-1:0] b_out,
  output logic          csync_out
);

  logic          hs_prev, vs_prev;
  logic          hs_rise, vs_rise;
  logic          parity, parity_nxt;
  logic [1:0]    mode_act, mode_nxt;

  logic          s1_hs, s1_vs, s1_par;
  logic [1:0]    s1_mode;
  logic [DW-1:0] s1_r, s1_g, s1_b;
  logic [DW-1:0] att_r, att_g, att_b;
  logic          blank;

  // A vs rise restarts the field on parity 0 even if hs rises on the same strobe.
  always_comb begin
    hs_rise    = hs_in & ~hs_prev;
    vs_rise    = vs_in & ~vs_prev;
    parity_nxt = parity;
    mode_nxt   = mode_act;
    if (vs_rise)
      parity_nxt = 1'b0;
    else if (hs_rise)
      parity_nxt = ~parity;
    if (hs_rise || vs_rise)
      mode_nxt = scanlines;
  end

  sl_attenuate #(.DW(DW)) u_att_r (.value(s1_r), .mode(s1_mode), .enable(s1_par), .result(att_r));
  sl_attenuate #(.DW(DW)) u_att_g (.value(s1_g), .mode(s1_mode), .enable(s1_par), .result(att_g));
  sl_attenuate #(.DW(DW)) u_att_b (.value(s1_b), .mode(s1_mode), .enable(s1_par), .result(att_b));

  assign blank = s1_hs | s1_vs;

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      hs_prev  <= 1'b0;
      vs_prev  <= 1'b0;
      parity   <= 1'b0;
      mode_act <= 2'd0;
      s1_hs    <= 1'b0;
      s1_vs    <= 1'b0;
      s1_par   <= 1'b0;
      s1_mode  <= 2'd0;
      s1_r     <= '0;
      s1_g     <= '0;
      s1_b     <= '0;
      hs_out   <= 1'b0;
      vs_out   <= 1'b0;
      r_out    <= '0;
      g_out    <= '0;
      b_out    <= '0;
    end else if (ce_pix) begin
      hs_prev  <= hs_in;
      vs_prev  <= vs_in;
      parity   <= parity_nxt;
      mode_act <= mode_nxt;
      // The pixel carries the parity/mode of the line it opens or belongs to.
      s1_hs    <= hs_in;
      s1_vs    <= vs_in;
      s1_par   <= parity_nxt;
      s1_mode  <= mode_nxt;
      s1_r     <= r_in;
      s1_g     <= g_in;
      s1_b     <= b_in;
      hs_out   <= s1_hs;
      vs_out   <= s1_vs;
      r_out    <= blank ? '0 : att_r;
      g_out    <= blank ? '0 : att_g;
      b_out    <= blank ? '0 : att_b;
    end
  end

`ifdef VIDEO_SCANLINES_CSYNC_EN
  logic csync_q;

  always_ff @(posedge clk_sys) begin
    if (!reset_n)
      csync_q <= 1'b0;
    else if (ce_pix)
      csync_q <= s1_hs ^ s1_vs;
  end

  assign csync_out = csync_q;
`else
  assign csync_out = 1'b0;
`endif

endmodule

// File: tb/tb_video_scanlines.sv
// Directed bench for video_scanlines (HALF_DEPTH=0): dimming modes, parity, sync blanking,
// strobe gating and reset; expected pixel values are given per step and delayed two strobes.
module tb_video_scanlines;

  localparam int DW = 6;

  logic          clk_sys = 1'b0;
  logic          reset_n;
  logic          ce_pix;
  logic [1:0]    scanlines;
  logic          hs_in, vs_in;
  logic [DW-1:0] r_in, g_in, b_in;
  logic          hs_out, vs_out;
  logic [DW-1:0] r_out, g_out, b_out;
  logic          csync_out;

  int checks   = 0;
  int failures = 0;
  logic [20:0] s1_exp, s2_exp;
  logic        slow = 1'b0;

  video_scanlines #(.HALF_DEPTH(0)) dut (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .ce_pix    (ce_pix),
    .scanlines (scanlines),
    .hs_in     (hs_in),
    .vs_in     (vs_in),
    .r_in      (r_in),
    .g_in      (g_in),
    .b_in      (b_in),
    .hs_out    (hs_out),
    .vs_out    (vs_out),
    .r_out     (r_out),
    .g_out     (g_out),
    .b_out     (b_out),
    .csync_out (csync_out)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  function automatic logic [20:0] pack(input logic h, input logic v, input logic [DW-1:0] c);
    logic cs;
`ifdef VIDEO_SCANLINES_CSYNC_EN
    cs = h ^ v;
`else
    cs = 1'b0;
`endif
    return {h, v, c, c, c, cs};
  endfunction

  task automatic check(input string tag, input logic [20:0] exp);
    logic [20:0] obs;
    obs = {hs_out, vs_out, r_out, g_out, b_out, csync_out};
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // e is the colour this pixel must show two strobes later if not blanked by sync.
  task automatic step(input string tag, input logic h, input logic v,
                      input logic [DW-1:0] c, input logic [DW-1:0] e);
    hs_in  = h;
    vs_in  = v;
    r_in   = c;
    g_in   = c;
    b_in   = c;
    ce_pix = 1'b1;
    tick();
    s2_exp = s1_exp;
    s1_exp = pack(h, v, (h | v) ? 6'h00 : e);
    check(tag, s2_exp);
    if (slow) begin
      ce_pix = 1'b0;
      r_in   = ~c;
      g_in   = ~c;
      b_in   = ~c;
      for (int i = 0; i < 3; i++) begin
        tick();
        check({tag, "_hold"}, s2_exp);
      end
    end
  endtask

  task automatic line_start(input string tag, input logic v, input logic [DW-1:0] c);
    step(tag, 1'b1, v, c, 6'h00);
    step(tag, 1'b1, v, c, 6'h00);
  endtask

  task automatic run(input string tag, input int n, input logic [DW-1:0] c, input logic [DW-1:0] e);
    for (int i = 0; i < n; i++) step(tag, 1'b0, 1'b0, c, e);
  endtask

  initial begin
    reset_n   = 1'b0;
    ce_pix    = 1'b1;
    scanlines = 2'd2;
    hs_in     = 1'b1;
    vs_in     = 1'b1;
    r_in      = 6'h3F;
    g_in      = 6'h3F;
    b_in      = 6'h3F;
    s1_exp    = '0;
    s2_exp    = '0;
    tick();
    tick();
    check("reset_state", 21'h0);

    // Mode 2 on full white; active mode is still 0 until the first line start.
    hs_in   = 1'b0;
    vs_in   = 1'b0;
    reset_n = 1'b1;
    run("pre_line", 3, 6'h3F, 6'h3F);
    for (int l = 1; l <= 4; l++) begin
      line_start("m2_hs", 1'b0, 6'h3F);
      run((l % 2 == 1) ? "m2_odd" : "m2_even", 14, 6'h3F, (l % 2 == 1) ? 6'h1F : 6'h3F);
    end

    // Odd lines under modes 1, 3, 0 on mid-grey 0x20.
    scanlines = 2'd1;
    line_start("m1_hs", 1'b0, 6'h20);
    run("m1_odd", 4, 6'h20, 6'h18);
    scanlines = 2'd3;
    line_start("even_a_hs", 1'b0, 6'h20);
    run("even_a", 4, 6'h20, 6'h20);
    line_start("m3_hs", 1'b0, 6'h20);
    run("m3_odd", 4, 6'h20, 6'h08);
    scanlines = 2'd0;
    line_start("even_b_hs", 1'b0, 6'h20);
    run("even_b", 4, 6'h20, 6'h20);

    // Mode change mid odd line only applies from the next line start.
    line_start("m0_hs", 1'b0, 6'h20);
    run("m0_odd", 3, 6'h20, 6'h20);
    scanlines = 2'd2;
    run("m0_odd_late", 3, 6'h20, 6'h20);
    line_start("even_c_hs", 1'b0, 6'h20);
    run("even_c", 4, 6'h20, 6'h20);
    line_start("m2b_hs", 1'b0, 6'h20);
    run("m2b_odd", 4, 6'h20, 6'h10);

    // vs and hs rising together: parity forced to 0 despite the hs edge.
    line_start("vs_hs", 1'b1, 6'h20);
    run("after_vs", 4, 6'h20, 6'h20);
    line_start("post_vs_hs", 1'b0, 6'h20);
    run("post_vs_odd", 4, 6'h20, 6'h10);

    // Strobe every 4th cycle: outputs hold through idle cycles.
    slow = 1'b1;
    line_start("slow_even_hs", 1'b0, 6'h20);
    run("slow_even", 3, 6'h20, 6'h20);
    line_start("slow_odd_hs", 1'b0, 6'h20);
    run("slow_odd", 2, 6'h20, 6'h10);

    // One-cycle reset mid odd line, with no strobe present.
    reset_n = 1'b0;
    ce_pix  = 1'b0;
    tick();
    reset_n = 1'b1;
    s1_exp  = '0;
    s2_exp  = '0;
    check("mid_reset", 21'h0);
    run("post_reset", 2, 6'h20, 6'h20);
    line_start("post_reset_hs", 1'b0, 6'h20);
    run("post_reset_odd", 3, 6'h20, 6'h10);
    line_start("post_reset_even_hs", 1'b0, 6'h20);
    run("post_reset_even", 2, 6'h20, 6'h20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/video_scanlines.md
VIDEO_SCANLINES -- requirements
Module: video_scanlines

Interface
REQ-001 Parameter HALF_DEPTH, default 0: 0 = 6-bit colour channels, 1 = 3-bit; DW = HALF_DEPTH ? 3 : 6.
REQ-002 clk_sys  in  1  system clock; all logic SHALL be clocked on its rising edge.
REQ-003 reset_n  in  1  synchronous, active-low reset.
REQ-004 ce_pix  in  1  output-rate pixel strobe; the block SHALL advance only when ce_pix=1.
REQ-005 scanlines  in  2  attenuation mode: 0 off, 1 75%, 2 50%, 3 25%.
REQ-006 hs_in, vs_in  in  1 each  active-high syncs from the scandoubler.
REQ-007 r_in, g_in, b_in  in  DW each  doubled-line colour.
REQ-008 hs_out, vs_out  out  1 each  syncs delayed to match colour.
REQ-009 r_out, g_out, b_out  out  DW each  attenuated colour.
REQ-010 csync_out  out  1  composite sync.

Function
REQ-011 Pipeline SHALL be 2 ce_pix strobes deep for colour, hs and vs alike: stage 1 registers inputs, stage 2 registers the attenuated result.
REQ-012 Between strobes, all registers and outputs SHALL hold.
REQ-013 Line start SHALL be a rising edge of hs_in, sampled on ce_pix against the previous sampled hs_in.
REQ-014 Parity bit SHALL toggle at each line start.
REQ-015 A rising edge of vs_in (sampled on ce_pix) SHALL force parity to 0; it SHALL win over a simultaneous hs_in rise.
REQ-016 The scanlines input SHALL be latched into an active-mode register only at line start or at vs_in rise; mid-line changes SHALL take effect from the next line.
REQ-017 Parity 0 lines SHALL pass unchanged.
REQ-018 Parity 1 lines SHALL be attenuated per channel, using the active mode:
- mode 0: x
- mode 1: x - (x>>2)
- mode 2: x>>1
- mode 3: x>>2
REQ-019 Attenuation SHALL use unsigned, truncating shifts within DW bits; no overflow is possible.
REQ-020 Attenuation SHALL use the parity and mode in force when the pixel entered stage 1.
REQ-021 While the stage-1 copy of hs_in or vs_in is 1, stage 2 SHALL force colour to 0 (blank in sync).

Reset
REQ-022 While reset_n=0 at a clock edge, regardless of ce_pix:
- all pipeline registers, hs_out, vs_out, r/g/b_out and csync_out SHALL become 0;
- parity SHALL become 0;
- active mode SHALL become 0;
- previous-hs and previous-vs samples SHALL become 0.
REQ-023 A reset mid-line SHALL discard in-flight pixels.
REQ-024 After release, the first ce_pix on which hs_in=1 SHALL count as a line start.

Configuration
REQ-025 With macro VIDEO_SCANLINES_CSYNC_EN defined, csync_out SHALL equal the stage-2 hs XOR the stage-2 vs, registered in stage 2, so it stays aligned with hs_out/vs_out.
REQ-026 Without VIDEO_SCANLINES_CSYNC_EN, csync_out SHALL be constant 0, the XOR logic SHALL be absent, and the port SHALL remain.

Structure
REQ-027 A shared package video_pkg SHALL hold:
- mode encodings SL_OFF=0, SL_75=1, SL_50=2, SL_25=3;
- the DW derivation from HALF_DEPTH;
- pipeline depth constant SL_LATENCY=2.
REQ-028 One sub-module, sl_attenuate, SHALL be instantiated once per channel: combinational, with inputs DW-bit value, 2-bit mode and 1-bit enable, and a DW-bit output.
REQ-029 Edge detection, parity, mode latching and pipeline registers SHALL live in the top module.

Verification
REQ-030 Mode 2, HALF_DEPTH=0, constant r/g/b=6'h3F, ce_pix every cycle, hs_in pulses every 16 strobes -> r/g/b_out alternate between 6'h3F lines and 6'h1F lines, 2 strobes after input, and are 0 during hs.
REQ-031 Mode 1, input 6'h20 on odd lines -> 6'h18; mode 3 -> 6'h08; mode 0 -> 6'h20.
REQ-032 vs_in and hs_in rise on the same ce_pix -> the next line is parity 0, i.e. unattenuated.
REQ-033 scanlines changed from 0 to 2 mid odd line -> that line stays unattenuated; the next odd line is halved.
REQ-034 ce_pix asserted every 4th cycle -> outputs change only on the cycle after a strobe, with latency of 2 strobes (8 cycles); reset_n=0 for 1 cycle mid-line -> all outputs 0 on the next cycle and parity restarts at 0.
REQ-035 With VIDEO_SCANLINES_CSYNC_EN: hs=1, vs=0 -> csync_out=1; hs=1, vs=1 -> 0. Without the macro: csync_out=0 throughout.
